// File: rtl/xs_cen_gen_multi.sv
// xs_cen_gen_multi: multi-channel clock-enable generator on the 48 MHz master clock.
// Each channel has a programmable divisor and phase. It produces a primary enable
// strobe, a strobe offset by half a period, and a counter-wrap strobe.
// Optional fractional-rate enable: define XSCEN_FRAC_EN to add i_frac_num,
// i_frac_den and o_cen_frac.
//
// Handshake / control semantics: there is no valid/ready traffic here. The control
// inputs are level-sampled on every rising edge, and their priority is
// reset > sync > pause > count.
// o_hold_dbg[k] shows the channel state: 0 = RUN, 1 = HOLD (paused).
module xs_cen_gen_multi #(
  parameter int NCH = 4,
  parameter int CW  = 8,
  parameter int FW  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NCH*CW-1:0] i_div,
  input  logic [NCH*CW-1:0] i_phase,
  input  logic              i_sync,
  input  logic              i_pause,
`ifdef XSCEN_FRAC_EN
  input  logic [FW-1:0]     i_frac_num,
  input  logic [FW-1:0]     i_frac_den,
  output logic              o_cen_frac,
`endif
  output logic [NCH-1:0]    o_cen,
  output logic [NCH-1:0]    o_cen180,
  output logic [NCH-1:0]    o_wrap,
  output logic [NCH-1:0]    o_hold_dbg
);

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} st_e;

  // Reject degenerate widths at elaboration time.
  if (NCH < 1 || CW < 1 || FW < 1) begin : g_param_check
    $error("xs_cen_gen_multi: NCH, CW and FW must all be >= 1");
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CW-1:0] cnt_q, div_sh_q, ph_sh_q;
    logic          cen_q, cen180_q, wrap_q;
    st_e           st_q;

    logic [CW-1:0] div_nx, ph_nx;
    logic [CW:0]   period_w, half_w, sum_w, tgt180_w;
    logic          ph_ok_w, at_end_w;

    // Compute the strobe targets from the shadowed divisor and phase.
    // The half-period sum uses CW+1 bits, so it cannot overflow before the modulo.
    always_comb begin
      div_nx   = i_div[k*CW +: CW];
      ph_nx    = i_phase[k*CW +: CW];
      period_w = {1'b0, div_sh_q} + (CW+1)'(1);
      half_w   = period_w >> 1;
      sum_w    = {1'b0, ph_sh_q} + half_w;
      tgt180_w = (sum_w >= period_w) ? (sum_w - period_w) : sum_w;
      ph_ok_w  = (ph_sh_q <= div_sh_q);
      at_end_w = (cnt_q == div_sh_q);
    end

    // Channel counter, shadow registers, state and registered strobes.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        cnt_q    <= '0;
        div_sh_q <= div_nx;
        ph_sh_q  <= ph_nx;
        cen_q    <= 1'b0;
        cen180_q <= 1'b0;
        wrap_q   <= 1'b0;
        st_q     <= ST_RUN;
      end else if (i_sync) begin
        cnt_q    <= '0;
        div_sh_q <= div_nx;
        ph_sh_q  <= ph_nx;
        cen_q    <= 1'b0;
        cen180_q <= 1'b0;
        wrap_q   <= 1'b0;
        st_q     <= i_pause ? ST_HOLD : ST_RUN;
      end else if (i_pause) begin
        cen_q    <= 1'b0;
        cen180_q <= 1'b0;
        wrap_q   <= 1'b0;
        st_q     <= ST_HOLD;
      end else begin
        st_q     <= ST_RUN;
        cen_q    <= ph_ok_w && (cnt_q == ph_sh_q);
        cen180_q <= ph_ok_w && ({1'b0, cnt_q} == tgt180_w);
        wrap_q   <= at_end_w;
        if (at_end_w) begin
          // New divisor and phase take effect only at a period boundary.
          cnt_q    <= '0;
          div_sh_q <= div_nx;
          ph_sh_q  <= ph_nx;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end

    assign o_cen[k]      = cen_q;
    assign o_cen180[k]   = cen180_q;
    assign o_wrap[k]     = wrap_q;
    assign o_hold_dbg[k] = (st_q == ST_HOLD);
  end

`ifdef XSCEN_FRAC_EN
  logic [FW:0] acc_q;
  logic        cen_frac_q;
  logic [FW:0] acc_n_w, den_w;

  // Next accumulator value, widened by one bit so the sum cannot overflow.
  always_comb begin
    acc_n_w = acc_q + {1'b0, i_frac_num};
    den_w   = {1'b0, i_frac_den};
  end

  // Fractional-rate accumulator: emit a strobe each time the accumulator passes den.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q      <= '0;
      cen_frac_q <= 1'b0;
    end else if (i_sync) begin
      acc_q      <= '0;
      cen_frac_q <= 1'b0;
    end else if (i_pause) begin
      cen_frac_q <= 1'b0;
    end else if (den_w == '0) begin
      acc_q      <= '0;
      cen_frac_q <= 1'b0;
    end else if (acc_n_w >= den_w) begin
      acc_q      <= acc_n_w - den_w;
      cen_frac_q <= 1'b1;
    end else begin
      acc_q      <= acc_n_w;
      cen_frac_q <= 1'b0;
    end
  end

  assign o_cen_frac = cen_frac_q;
`endif

endmodule

// File: tb/tb_xs_cen_gen_multi.sv
// Directed testbench for xs_cen_gen_multi (NCH=2, CW=8).
// Edge n counts the rising edges after reset is released, starting at n = 1.
module tb_xs_cen_gen_multi;
  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int FW  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*CW-1:0] div, phase;
  logic              sync, pause;
  logic [NCH-1:0]    cen, cen180, wrap, hold_dbg;
`ifdef XSCEN_FRAC_EN
  logic [FW-1:0]     frac_num, frac_den;
  logic              cen_frac;
`endif

  int errors = 0;
  int checks = 0;

  // Clock generation.
  always #5 clk = ~clk;

  xs_cen_gen_multi #(.NCH(NCH), .CW(CW), .FW(FW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_div      (div),
    .i_phase    (phase),
    .i_sync     (sync),
    .i_pause    (pause),
`ifdef XSCEN_FRAC_EN
    .i_frac_num (frac_num),
    .i_frac_den (frac_den),
    .o_cen_frac (cen_frac),
`endif
    .o_cen      (cen),
    .o_cen180   (cen180),
    .o_wrap     (wrap),
    .o_hold_dbg (hold_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with the given settings, then release it.
  task automatic do_reset(input logic [7:0] d0, input logic [7:0] p0,
                          input logic [7:0] d1, input logic [7:0] p1);
    rst_n = 1'b0;
    sync  = 1'b0;
    pause = 1'b0;
    div   = {d1, d0};
    phase = {p1, p0};
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sync  = 1'b0;
    pause = 1'b0;
    div   = {8'd7, 8'd3};
    phase = {8'd1, 8'd3};
    tick();
    tick();
    checks++;
    if ({cen, cen180, wrap} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", {cen, cen180, wrap});
    end
    checks++;
    if (hold_dbg !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got %b expected 00", hold_dbg);
    end
    rst_n = 1'b1;
  endtask

  // ch0 div=3 ph=3, ch1 div=7 ph=1.
  task automatic test_basic();
    logic [1:0] e_cen, e_c180, e_wrap;
    do_reset(8'd3, 8'd3, 8'd7, 8'd1);
    for (int n = 1; n <= 16; n++) begin
      tick();
      e_cen  = {n % 8 == 2, n % 4 == 0};
      e_c180 = {n % 8 == 6, n % 4 == 2};
      e_wrap = {n % 8 == 0, n % 4 == 0};
      checks++;
      if ({cen, cen180, wrap} !== {e_cen, e_c180, e_wrap}) begin
        errors++;
        $display("FAIL basic n=%0d: cen/c180/wrap got %b expected %b", n,
                 {cen, cen180, wrap}, {e_cen, e_c180, e_wrap});
      end
    end
  endtask

  // A divisor change while cnt=1 takes effect only after the current period ends.
  task automatic test_div_change();
    logic e_w, e_c;
    do_reset(8'd3, 8'd0, 8'd7, 8'd1);
    for (int n = 1; n <= 12; n++) begin
      tick();
      e_w = (n == 4 || n == 6 || n == 8 || n == 10 || n == 12);
      e_c = (n == 1 || n == 5 || n == 7 || n == 9 || n == 11);
      checks++;
      if ({cen[0], wrap[0]} !== {e_c, e_w}) begin
        errors++;
        $display("FAIL div_change n=%0d: cen0/wrap0 got %b expected %b", n,
                 {cen[0], wrap[0]}, {e_c, e_w});
      end
      if (n == 1) div[7:0] = 8'd1;
    end
  endtask

  // Pause for five edges while cnt=2.
  task automatic test_pause();
    do_reset(8'd3, 8'd3, 8'd7, 8'd1);
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (n >= 3 && n <= 7) begin
        checks++;
        if ({cen, cen180, wrap} !== 6'b0) begin
          errors++;
          $display("FAIL pause_quiet n=%0d: got %b expected 000000", n, {cen, cen180, wrap});
        end
        checks++;
        if (hold_dbg !== 2'b11) begin
          errors++;
          $display("FAIL pause_state n=%0d: got %b expected 11", n, hold_dbg);
        end
      end else begin
        checks++;
        if (hold_dbg !== 2'b00) begin
          errors++;
          $display("FAIL run_state n=%0d: got %b expected 00", n, hold_dbg);
        end
      end
      checks++;
      if (cen[0] !== (n == 9 || n == 13)) begin
        errors++;
        $display("FAIL pause_cen0 n=%0d: got %b expected %b", n, cen[0], (n == 9 || n == 13));
      end
      if (n == 2) pause = 1'b1;
      if (n == 7) pause = 1'b0;
    end
  endtask

  // Sync and pause together: counters go to 0 and stay there while paused.
  task automatic test_sync_pause();
    do_reset(8'd3, 8'd0, 8'd7, 8'd1);
    tick();
    tick();
    sync  = 1'b1;
    pause = 1'b1;
    tick();
    checks++;
    if ({cen, cen180, wrap} !== 6'b0) begin
      errors++;
      $display("FAIL sync_outputs: got %b expected 000000", {cen, cen180, wrap});
    end
    sync = 1'b0;
    tick();
    tick();
    checks++;
    if ({cen, cen180, wrap} !== 6'b0) begin
      errors++;
      $display("FAIL sync_hold_outputs: got %b expected 000000", {cen, cen180, wrap});
    end
    pause = 1'b0;
    tick();
    checks++;
    if (cen !== 2'b01) begin
      errors++;
      $display("FAIL sync_restart_a: cen got %b expected 01", cen);
    end
    tick();
    checks++;
    if (cen !== 2'b10) begin
      errors++;
      $display("FAIL sync_restart_b: cen got %b expected 10", cen);
    end
  endtask

  // ch0: phase beyond divisor never fires. ch1: div=0 fires every cycle. Then reset mid-run.
  task automatic test_ph_gt_div();
    logic [5:0] exp_v;
    do_reset(8'd3, 8'd5, 8'd0, 8'd0);
    for (int n = 1; n <= 64; n++) begin
      tick();
      exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, n % 4 == 0};
      checks++;
      if ({cen, cen180, wrap} !== exp_v) begin
        errors++;
        $display("FAIL ph_gt_div n=%0d: got %b expected %b", n, {cen, cen180, wrap}, exp_v);
      end
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({cen, cen180, wrap} !== 6'b0) begin
      errors++;
      $display("FAIL midrun_reset: got %b expected 000000", {cen, cen180, wrap});
    end
    rst_n = 1'b1;
  endtask

`ifdef XSCEN_FRAC_EN
  task automatic test_frac();
    frac_num = 16'd3;
    frac_den = 16'd8;
    do_reset(8'd3, 8'd0, 8'd7, 8'd0);
    for (int n = 1; n <= 16; n++) begin
      tick();
      checks++;
      if (cen_frac !== (n % 8 == 3 || n % 8 == 6 || n % 8 == 0)) begin
        errors++;
        $display("FAIL frac n=%0d: got %b", n, cen_frac);
      end
    end
    frac_den = 16'd0;
    do_reset(8'd3, 8'd0, 8'd7, 8'd0);
    for (int n = 1; n <= 16; n++) begin
      tick();
      checks++;
      if (cen_frac !== 1'b0) begin
        errors++;
        $display("FAIL frac_den0 n=%0d: got %b expected 0", n, cen_frac);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    sync  = 1'b0;
    pause = 1'b0;
    div   = '0;
    phase = '0;
`ifdef XSCEN_FRAC_EN
    frac_num = '0;
    frac_den = '0;
`endif
    test_reset();
    test_basic();
    test_div_change();
    test_pause();
    test_sync_pause();
    test_ph_gt_div();
`ifdef XSCEN_FRAC_EN
    test_frac();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
